// File: rtl/univ_shift_reg.sv
// Universal shift register: single-step shift/rotate/load every cycle in IDLE,
// or a launched multi-step operation that runs for a latched step count.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] p_in,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] out,
  output logic             sr_out,
  output logic             sl_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             launch;

  // One step of any mode; reserved and hold codes keep the value.
  function automatic logic [WIDTH-1:0] apply_step(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] load_val,
    input logic             sr,
    input logic             sl
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (m)
      MODE_SHR:  res = {sr, cur[WIDTH-1:1]};
      MODE_SHL:  res = {cur[WIDTH-2:0], sl};
      MODE_LOAD: res = load_val;
      MODE_ROR:  res = {cur[0], cur[WIDTH-1:1]};
      MODE_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default:   res = cur;
    endcase
    return res;
  endfunction

  assign launch = start && (mode inside {MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR});

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          mode_d  = mode;
          cnt_d   = shamt;
          state_d = (shamt != '0) ? RUN : DONE;
        end else begin
          out_d = apply_step(mode, out_q, p_in, sr_in, sl_in);
        end
      end
      RUN: begin
        // Latched mode only; the load value is irrelevant since LOAD never launches.
        out_d = apply_step(mode_q, out_q, out_q, sr_in, sl_in);
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign out    = out_q;
  assign sr_out = out_q[0];
  assign sl_out = out_q[WIDTH-1];
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed-vector bench for univ_shift_reg with hand-computed expected values.
module tb_univ_shift_reg;

  logic       clk;
  logic       rst;
  logic [2:0] mode;
  logic [7:0] p_in;
  logic       sr_in;
  logic       sl_in;
  logic       start;
  logic [3:0] shamt;
  logic [7:0] out;
  logic       sr_out;
  logic       sl_out;
  logic       busy;
  logic       done;

  int checkCount = 0;
  int passCount  = 0;
  int busyCycles;
  bit doneSeen;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .p_in(p_in),
    .sr_in(sr_in),
    .sl_in(sl_in),
    .start(start),
    .shamt(shamt),
    .out(out),
    .sr_out(sr_out),
    .sl_out(sl_out),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadValue(input logic [7:0] value);
    mode = 3'b011;
    p_in = value;
    tick();
    mode = 3'b000;
  endtask

  // Launch a multi-step op and wait (bounded) for done; optionally disturb the run.
  task automatic applyStimulus(input logic [2:0] m, input logic [3:0] n, input bit disturb);
    mode  = m;
    shamt = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = 3'b000;
    busyCycles = 0;
    doneSeen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        doneSeen = 1'b1;
        break;
      end
      if (busy) busyCycles++;
      if (disturb && busyCycles == 2) begin
        mode  = 3'b011;
        p_in  = 8'h00;
        start = 1'b1;
        shamt = 4'd1;
      end else begin
        mode  = 3'b000;
        start = 1'b0;
      end
      tick();
    end
    mode  = 3'b000;
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    mode  = 3'b000;
    p_in  = 8'h00;
    sr_in = 1'b0;
    sl_in = 1'b0;
    start = 1'b0;
    shamt = 4'd0;
    #1;
    checkOutput("reset_out", {24'd0, out}, 32'h00);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-step shifts in IDLE
    loadValue(8'hFF);
    checkOutput("load_ff", {24'd0, out}, 32'hFF);
    mode = 3'b001; sr_in = 1'b0;
    tick();
    checkOutput("shr_1", {24'd0, out}, 32'h7F);
    tick(); tick(); tick();
    checkOutput("shr_4", {24'd0, out}, 32'h0F);
    checkOutput("sr_out", {31'd0, sr_out}, 32'd1);
    checkOutput("sl_out", {31'd0, sl_out}, 32'd0);
    mode = 3'b010; sl_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("shl_4", {24'd0, out}, 32'hFF);
    sl_in = 1'b0;

    // Hold codes, rotate and arithmetic single steps
    loadValue(8'h81);
    mode = 3'b000; tick();
    checkOutput("hold_000", {24'd0, out}, 32'h81);
    mode = 3'b111; start = 1'b1; tick(); start = 1'b0;
    checkOutput("hold_111_start", {24'd0, out}, 32'h81);
    checkOutput("hold_111_busy", {31'd0, busy}, 32'd0);
    mode = 3'b100; tick();
    checkOutput("ror_1", {24'd0, out}, 32'hC0);
    mode = 3'b101; tick();
    checkOutput("rol_1", {24'd0, out}, 32'h81);
    mode = 3'b110; tick();
    checkOutput("asr_1", {24'd0, out}, 32'hC0);
    p_in = 8'h5A; mode = 3'b011; start = 1'b1; tick(); start = 1'b0;
    checkOutput("load_with_start", {24'd0, out}, 32'h5A);
    checkOutput("load_start_busy", {31'd0, busy}, 32'd0);
    mode = 3'b000;

    // Rotate left A5 by 3, watching every step
    loadValue(8'hA5);
    mode = 3'b101; shamt = 4'd3; start = 1'b1;
    tick();
    start = 1'b0; mode = 3'b000;
    checkOutput("rol3_launch_out", {24'd0, out}, 32'hA5);
    checkOutput("rol3_launch_busy", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("rol3_step1", {24'd0, out}, 32'h4B);
    checkOutput("rol3_busy1", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("rol3_step2", {24'd0, out}, 32'h96);
    tick();
    checkOutput("rol3_step3", {24'd0, out}, 32'h2D);
    checkOutput("rol3_done", {31'd0, done}, 32'd1);
    checkOutput("rol3_done_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("rol3_done_drop", {31'd0, done}, 32'd0);
    checkOutput("rol3_hold", {24'd0, out}, 32'h2D);

    // Arithmetic shift right, including an over-width count
    loadValue(8'h80);
    applyStimulus(3'b110, 4'd2, 1'b0);
    checkOutput("asr2_out", {24'd0, out}, 32'hE0);
    checkOutput("asr2_busy_cycles", busyCycles, 32'd2);
    checkOutput("asr2_done_seen", {31'd0, doneSeen}, 32'd1);
    tick();
    applyStimulus(3'b110, 4'd8, 1'b0);
    checkOutput("asr8_out", {24'd0, out}, 32'hFF);
    checkOutput("asr8_busy_cycles", busyCycles, 32'd8);
    tick();

    // Zero count goes straight to DONE
    loadValue(8'h3C);
    applyStimulus(3'b001, 4'd0, 1'b0);
    checkOutput("zero_busy_cycles", busyCycles, 32'd0);
    checkOutput("zero_done_seen", {31'd0, doneSeen}, 32'd1);
    checkOutput("zero_out", {24'd0, out}, 32'h3C);
    tick();
    checkOutput("zero_done_drop", {31'd0, done}, 32'd0);

    // Live serial input during RUN, and shift saturation past width
    loadValue(8'h00);
    sr_in = 1'b1;
    applyStimulus(3'b001, 4'd3, 1'b0);
    checkOutput("shr3_live_sr", {24'd0, out}, 32'hE0);
    tick();
    sr_in = 1'b0;
    loadValue(8'hFF);
    sl_in = 1'b0;
    applyStimulus(3'b010, 4'd10, 1'b0);
    checkOutput("shl10_sat", {24'd0, out}, 32'h00);
    checkOutput("shl10_busy_cycles", busyCycles, 32'd10);
    tick();

    // Disturbed rotate right by 9 wraps to a single rotate
    loadValue(8'h01);
    applyStimulus(3'b100, 4'd9, 1'b1);
    checkOutput("ror9_disturbed", {24'd0, out}, 32'h80);
    checkOutput("ror9_busy_cycles", busyCycles, 32'd9);
    checkOutput("ror9_done_seen", {31'd0, doneSeen}, 32'd1);
    tick();

    // Asynchronous reset in the middle of a run
    loadValue(8'hA5);
    mode = 3'b101; shamt = 4'd4; start = 1'b1;
    tick();
    start = 1'b0; mode = 3'b000;
    tick();
    checkOutput("abort_step1", {24'd0, out}, 32'h4B);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_out", {24'd0, out}, 32'h00);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) doneSeen = 1'b1;
    end
    checkOutput("abort_no_done", {31'd0, doneSeen}, 32'd0);
    checkOutput("abort_idle_out", {24'd0, out}, 32'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
